// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared constants, state encoding and BHT counter helper for branch resolution
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESOLVE  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // Saturating 2-bit counter step: taken moves toward ST, not-taken toward SNT.
    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_bht.sv
// rtl/branch_resolve_ctrl_bht.sv - 2-bit saturating branch history table with async read
module branch_bht
    import branch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] ctr_q [ENTRIES];

    // Read returns the stored value, so a same-cycle update is seen only next cycle.
    assign rd_pred = ctr_q[rd_idx][1];

    // Counter array: all entries start weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_en) begin
            ctr_q[upd_idx] <= bht_next(ctr_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - execute-stage branch/jump resolution, redirect and flush sequencing
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_IDX_W    = 6,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic             resolve_valid,
    output logic             resolve_taken,
    output logic             illegal_funct3,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t state_q, state_d;

    logic [2:0]      op_funct3_q;
    logic            op_is_jal_q;
    logic            op_is_jalr_q;
    logic [XLEN-1:0] op_pc_q;
    logic [XLEN-1:0] op_rs1_q;
    logic [XLEN-1:0] op_rs2_q;
    logic [XLEN-1:0] op_imm_q;
    logic            op_pred_q;

    logic [FC_W-1:0] flush_cnt_q;
    logic            redir_first_q;

    logic            eq, less, less_u;
    logic            cond_taken, f3_illegal;
    logic            is_cond, taken, illegal_op, mispredict;
    logic [XLEN-1:0] target, fallthrough, jalr_sum;
    logic            bht_upd_en;

    logic            unused_if_pc;
    assign unused_if_pc = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

    assign eq     = (op_rs1_q == op_rs2_q);
    assign less   = ($signed(op_rs1_q) < $signed(op_rs2_q));
    assign less_u = (op_rs1_q < op_rs2_q);

    // Condition decode; 010/011 are reserved and never taken.
    always_comb begin
        cond_taken = 1'b0;
        f3_illegal = 1'b0;
        case (op_funct3_q)
            F3_BEQ:  cond_taken = eq;
            F3_BNE:  cond_taken = !eq;
            F3_BLT:  cond_taken = less;
            F3_BGE:  cond_taken = !less;
            F3_BLTU: cond_taken = less_u;
            F3_BGEU: cond_taken = !less_u;
            default: f3_illegal = 1'b1;
        endcase
    end

    assign is_cond     = !op_is_jal_q && !op_is_jalr_q;
    assign taken       = is_cond ? cond_taken : 1'b1;
    assign illegal_op  = is_cond && f3_illegal;
    assign jalr_sum    = op_rs1_q + op_imm_q;
    assign target      = op_is_jalr_q ? {jalr_sum[XLEN-1:1], 1'b0} : (op_pc_q + op_imm_q);
    assign fallthrough = op_pc_q + XLEN'(4);

    // No BTB, so JALR always redirects; JAL only redirects when fetch missed it.
    always_comb begin
        if (op_is_jalr_q) begin
            mispredict = 1'b1;
        end else if (op_is_jal_q) begin
            mispredict = !op_pred_q;
        end else begin
            mispredict = (taken != op_pred_q);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_d        = state_q;
        ex_ready       = 1'b0;
        resolve_valid  = 1'b0;
        resolve_taken  = 1'b0;
        illegal_funct3 = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        bht_upd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                ex_ready = 1'b1;
                if (ex_valid) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                resolve_valid  = 1'b1;
                resolve_taken  = taken;
                illegal_funct3 = illegal_op;
                bht_upd_en     = is_cond && !f3_illegal;
                state_d        = mispredict ? REDIRECT : IDLE;
            end
            REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = redir_first_q;
                if (flush_cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_funct3_q  <= '0;
            op_is_jal_q  <= 1'b0;
            op_is_jalr_q <= 1'b0;
            op_pc_q      <= '0;
            op_rs1_q     <= '0;
            op_rs2_q     <= '0;
            op_imm_q     <= '0;
            op_pred_q    <= 1'b0;
        end else if (state_q == IDLE && ex_valid) begin
            op_funct3_q  <= ex_funct3;
            op_is_jal_q  <= ex_is_jal;
            op_is_jalr_q <= ex_is_jalr;
            op_pc_q      <= ex_pc;
            op_rs1_q     <= ex_rs1;
            op_rs2_q     <= ex_rs2;
            op_imm_q     <= ex_imm;
            op_pred_q    <= ex_pred_taken;
        end
    end

    // Redirect target, mispredict count and flush down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            flush_cnt_q    <= '0;
            redir_first_q  <= 1'b0;
        end else if (state_q == RESOLVE && mispredict) begin
            redirect_pc   <= taken ? target : fallthrough;
            flush_cnt_q   <= FC_W'(FLUSH_CYCLES - 1);
            redir_first_q <= 1'b1;
            if (mispredict_cnt != '1) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end else if (state_q == REDIRECT) begin
            redir_first_q <= 1'b0;
            if (flush_cnt_q != '0) begin
                flush_cnt_q <= flush_cnt_q - FC_W'(1);
            end
        end
    end

    branch_bht #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[BHT_IDX_W+1:2]),
        .rd_pred  (if_pred_taken),
        .upd_en   (bht_upd_en),
        .upd_idx  (op_pc_q[BHT_IDX_W+1:2]),
        .upd_taken(taken)
    );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_funct3;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_imm;
    logic        ex_pred_taken;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        illegal_funct3;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [15:0] mispredict_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .XLEN(32), .BHT_IDX_W(6), .FLUSH_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_funct3(ex_funct3), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .illegal_funct3(illegal_funct3),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .mispredict_cnt(mispredict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op; returns with the op in RESOLVE (1 ns after the accept edge).
    task automatic accept(input string tag, input logic [2:0] f3, input logic jal, input logic jalr,
                          input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic pred);
        for (int i = 0; i < 20 && !ex_ready; i++) tick();
        if (!ex_ready) chk({tag, ".ready_timeout"}, 32'(ex_ready), 32'd1);
        ex_funct3 = f3; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_pc = pc; ex_rs1 = rs1; ex_rs2 = rs2; ex_imm = imm; ex_pred_taken = pred;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic pred,
                         input logic exp_taken, input logic exp_ill, input logic exp_redir,
                         input logic [31:0] exp_rpc);
        accept(tag, f3, jal, jalr, pc, rs1, rs2, imm, pred);
        chk({tag, ".resolve_valid"}, 32'(resolve_valid), 32'd1);
        chk({tag, ".resolve_taken"}, 32'(resolve_taken), 32'(exp_taken));
        chk({tag, ".illegal"}, 32'(illegal_funct3), 32'(exp_ill));
        tick();
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(exp_redir));
        chk({tag, ".flush"}, 32'(flush), 32'(exp_redir));
        chk({tag, ".ex_ready"}, 32'(ex_ready), 32'(!exp_redir));
        if (exp_redir) begin
            chk({tag, ".redirect_pc"}, redirect_pc, exp_rpc);
            tick();
            chk({tag, ".redirect_valid2"}, 32'(redirect_valid), 32'd0);
            chk({tag, ".flush2"}, 32'(flush), 32'd1);
            tick();
            chk({tag, ".flush_end"}, 32'(flush), 32'd0);
            chk({tag, ".ready_end"}, 32'(ex_ready), 32'd1);
        end
    endtask

    task automatic chk_bht(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        chk(tag, 32'(if_pred_taken), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_funct3 = 3'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
        ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0; ex_pred_taken = 1'b0; if_pc = '0;
        repeat (2) tick();
        chk("rst.ex_ready", 32'(ex_ready), 32'd1);
        chk("rst.flush", 32'(flush), 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'd0);
        chk("rst.cnt", 32'(mispredict_cnt), 32'd0);
        chk_bht("rst.bht", 32'h100, 1'b0);
        rst_n = 1'b1;
        tick();

        // BEQ taken, predicted not-taken
        do_op("beq", 3'b000, 0, 0, 32'h100, 32'd5, 32'd5, 32'h20, 0, 1, 0, 1, 32'h120);
        chk("beq.cnt", 32'(mispredict_cnt), 32'd1);
        chk_bht("beq.bht", 32'h100, 1'b1);

        // signed vs unsigned compare on the same operands
        do_op("blt", 3'b100, 0, 0, 32'h304, 32'hFFFF_FFFF, 32'd1, 32'h10, 1, 1, 0, 0, 32'h0);
        do_op("bltu", 3'b110, 0, 0, 32'h308, 32'hFFFF_FFFF, 32'd1, 32'h10, 1, 0, 0, 1, 32'h30C);
        chk("bltu.cnt", 32'(mispredict_cnt), 32'd2);

        // BHT training: 01 -> 10 -> 11 -> 11, then one not-taken leaves 10
        if_pc = 32'h40;
        accept("bne1", 3'b001, 0, 0, 32'h40, 32'd1, 32'd2, 32'h8, 1);
        chk("bne1.pre_update_read", 32'(if_pred_taken), 32'd0);
        tick();
        chk_bht("bne1.bht", 32'h40, 1'b1);
        do_op("bne2", 3'b001, 0, 0, 32'h40, 32'd1, 32'd2, 32'h8, 1, 1, 0, 0, 32'h0);
        do_op("bne3", 3'b001, 0, 0, 32'h40, 32'd1, 32'd2, 32'h8, 1, 1, 0, 0, 32'h0);
        do_op("bne_nt", 3'b001, 0, 0, 32'h40, 32'd7, 32'd7, 32'h8, 0, 0, 0, 0, 32'h0);
        chk_bht("bne.saturated", 32'h40, 1'b1);

        // jumps: JALR always redirects with bit0 cleared; neither jump trains the BHT
        do_op("jalr", 3'b101, 0, 1, 32'h200, 32'h1001, 32'd0, 32'h4, 1, 1, 0, 1, 32'h1004);
        do_op("jal", 3'b000, 1, 0, 32'h210, 32'd0, 32'd0, 32'h100, 0, 1, 0, 1, 32'h310);
        chk_bht("jal.no_bht", 32'h210, 1'b0);
        chk("jal.cnt", 32'(mispredict_cnt), 32'd4);

        // reserved funct3
        do_op("ill", 3'b010, 0, 0, 32'h214, 32'd3, 32'd3, 32'h40, 0, 0, 1, 0, 32'h0);
        chk("ill.cnt", 32'(mispredict_cnt), 32'd4);

        // PC wrap on target and fallthrough
        do_op("bgeu_t", 3'b111, 0, 0, 32'hFFFF_FFFC, 32'd5, 32'd3, 32'd8, 0, 1, 0, 1, 32'h4);
        do_op("bgeu_nt", 3'b111, 0, 0, 32'hFFFF_FFFC, 32'd3, 32'd5, 32'd8, 1, 0, 0, 1, 32'h0);
        chk("wrap.cnt", 32'(mispredict_cnt), 32'd6);

        // async reset in the middle of a redirect
        accept("rst_mid", 3'b000, 0, 0, 32'h100, 32'd9, 32'd9, 32'h20, 0);
        tick();
        chk("rst_mid.flush_before", 32'(flush), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.flush", 32'(flush), 32'd0);
        chk("rst_mid.redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_mid.ex_ready", 32'(ex_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid.cnt", 32'(mispredict_cnt), 32'd0);
        chk_bht("rst_mid.bht100", 32'h100, 1'b0);
        chk_bht("rst_mid.bht40", 32'h40, 1'b0);
        chk_bht("rst_mid.bht304", 32'h304, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences conditional-branch and jump resolution for the core's execute stage. It accepts one control-transfer op at a time and computes the compare flags and taken decision per funct3. It checks the outcome against the fetch-time prediction and, on mismatch, drives a redirect PC plus a multi-cycle pipeline flush. It also owns the 2-bit branch history table (BHT) that fetch reads for predictions.

Parameters:
XLEN, 32, datapath/PC width
BHT_IDX_W, 6, log2 of BHT entries (64 entries of 2-bit counters)
FLUSH_CYCLES, 2, cycles flush stays asserted per redirect (>=1)
CNT_W, 16, mispredict counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_valid  in  1  EX offers a branch/jump op
ex_ready  out  1  controller can accept (high only in IDLE)
ex_funct3  in  3  branch condition code
ex_is_jal  in  1  op is JAL
ex_is_jalr  in  1  op is JALR
ex_pc  in  XLEN  PC of the op
ex_rs1  in  XLEN  operand 1
ex_rs2  in  XLEN  operand 2
ex_imm  in  XLEN  sign-extended offset
ex_pred_taken  in  1  prediction fetch used
if_pc  in  XLEN  fetch PC for BHT lookup
if_pred_taken  out  1  BHT counter MSB at if_pc index
resolve_valid  out  1  one-cycle pulse, op resolved
resolve_taken  out  1  actual outcome, valid with resolve_valid
illegal_funct3  out  1  one-cycle pulse, funct3 is 010/011 on a conditional op
redirect_valid  out  1  one-cycle pulse, redirect fetch
redirect_pc  out  XLEN  corrected fetch PC
flush  out  1  squash younger pipeline stages
mispredict_cnt  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (async, rst_n=0): state IDLE; ex_ready=1; resolve_valid, resolve_taken, illegal_funct3, redirect_valid, flush=0; redirect_pc=0; mispredict_cnt=0; all BHT entries=2'b01 (weakly not-taken). Reset during RESOLVE or REDIRECT aborts the op with no redirect and no BHT update.
- FSM states are IDLE, RESOLVE and REDIRECT.
- IDLE: ex_ready=1. On ex_valid&&ex_ready, latch all ex_* inputs and go to RESOLVE.
- RESOLVE (exactly 1 cycle after accept) computes:
  - eq = rs1==rs2; less = signed rs1<rs2; ge = !less; less_u = unsigned rs1<rs2; ge_u = !less_u.
  - taken by funct3: 000 eq, 001 !eq, 100 less, 101 ge, 110 less_u, 111 ge_u.
  - 010/011: taken=0 and illegal_funct3 pulses.
  - JAL/JALR: taken=1, funct3 ignored; JALR takes priority if both flags are set.
- Targets (all wrap mod 2^XLEN):
  - branch and JAL: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - fallthrough: pc+4.
- Mispredict rules:
  - Conditional branch: taken!=pred_taken.
  - JAL: pred_taken=0.
  - JALR: always a mispredict (no BTB).
- RESOLVE outputs and transitions:
  - resolve_valid=1 and resolve_taken=taken this cycle.
  - If mispredict: redirect_pc = taken ? target : pc+4; mispredict_cnt += 1 (saturates at all-ones); go to REDIRECT.
  - Otherwise go to IDLE.
- BHT update, in RESOLVE, conditional ops with legal funct3 only:
  - Index = pc[BHT_IDX_W+1:2].
  - Taken increments the counter, saturating at 11; not-taken decrements, saturating at 00.
  - JAL/JALR and illegal funct3 do not update.
- REDIRECT:
  - redirect_valid=1 on the first cycle only.
  - flush=1 for FLUSH_CYCLES cycles, counted by an internal down-counter; then IDLE.
  - ex_ready=0 throughout.
- BHT lookup: combinational read at index if_pc[BHT_IDX_W+1:2]. If the same index is read and updated in the same cycle, the read returns the pre-update value.
- Throughput: at most one op per 2 cycles (IDLE→RESOLVE→IDLE) when there is no mispredict. A mispredict takes 2+FLUSH_CYCLES cycles.

Decomposition:
- Shared package branch_pkg holds:
  - funct3 constants (F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU);
  - state enum {IDLE, RESOLVE, REDIRECT};
  - BHT counter constants (SNT=00, WNT=01, WT=10, ST=11).
- One sub-module, branch_bht: counter array with async reset, combinational read port and saturating update port.
- FSM, compare and target logic stay in the top.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=0 → resolve_taken=1; redirect_valid pulses 1 cycle with redirect_pc=0x120; flush high 2 cycles; mispredict_cnt=1.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred=1 → signed less gives taken=1, no redirect. BLTU with the same operands, pred=1 → taken=0, redirect_pc=pc+4.
- Same BNE at pc=0x40 taken 3 times, then if_pc=0x40 → BHT entry goes 01→10→11→11; if_pred_taken=1 after the first update.
- JALR, rs1=0x1001, imm=0x4, pc=0x200 → redirect_pc=0x1004, always redirected, no BHT change. funct3=010 conditional, pred=0 → illegal_funct3 pulse, taken=0, no redirect, no BHT change.
- pc=0xFFFFFFFC, BGEU taken, imm=8, pred=0 → redirect_pc=0x4 (wrap). Not-taken fallthrough from the same pc with pred=1 → redirect_pc=0x0.
- Deassert rst_n mid-REDIRECT (flush=1) → flush and redirect_valid drop immediately and ex_ready=1; after release the BHT reads 01 everywhere and mispredict_cnt=0.
